// File: rtl/div_entry_ctrl.sv
// -----------------------------------------------------------------------------
// div_entry_ctrl
// Sequencer between the keypad decoder and the integer divider. Collects two
// 2-nibble hex operands (A then B, high nibble first) and rejects a zero
// divisor. It pulses the divider start, waits for done with a timeout and
// latches the quotient and remainder. It also drives the 4-digit 7-seg mux
// with the entry digits, the result or an error pattern.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active low
//   key_valid    in   one-cycle debounced key event
//   key_code     in   hex value of the key, qualified by key_valid
//   clr          in   synchronous soft clear (level)
//   div_done     in   divider completion, only honoured while waiting
//   div_q/div_r  in   divider quotient / remainder, valid with div_done
//   div_start    out  one-cycle start pulse to the divider
//   A_bin/B_bin  out  dividend / divisor, stable from START until next entry
//   disp_data    out  4 hex digits, [15:12] leftmost
//   disp_blank   out  per-digit blank, bit3 leftmost
//   result_valid out  high while a result is shown
//   err          out  high while the error pattern is shown
//   busy         out  high while the divider is being started or awaited
// All outputs are registers or decodes of registered state only.
// -----------------------------------------------------------------------------
module div_entry_ctrl #(
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         clr,
    input  logic         div_done,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    output logic         div_start,
    output logic [W-1:0] A_bin,
    output logic [W-1:0] B_bin,
    output logic [15:0]  disp_data,
    output logic [3:0]   disp_blank,
    output logic         result_valid,
    output logic         err,
    output logic         busy
);

    localparam int             CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LIM = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_A_HI, S_A_LO, S_B_HI, S_B_LO, S_START, S_WAIT, S_SHOW, S_ERR
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a, r_b, r_q, r_r;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  w_b_full;

    // Divisor as it will be once the low-nibble key is written.
    assign w_b_full = {r_b[W-1:W-4], key_code};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_A_HI;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
        end else if (clr) begin
            // Soft clear beats any key or done on the same edge.
            r_state <= S_A_HI;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                // A key in SHOW/ERR starts a fresh entry exactly like A_HI.
                S_A_HI, S_SHOW, S_ERR: begin
                    if (key_valid) begin
                        r_a     <= {key_code, {(W-4){1'b0}}};
                        r_b     <= '0;
                        r_state <= S_A_LO;
                    end
                end
                S_A_LO: begin
                    if (key_valid) begin
                        r_a[3:0] <= key_code;
                        r_state  <= S_B_HI;
                    end
                end
                S_B_HI: begin
                    if (key_valid) begin
                        r_b[W-1:W-4] <= key_code;
                        r_state      <= S_B_LO;
                    end
                end
                S_B_LO: begin
                    if (key_valid) begin
                        r_b[3:0] <= key_code;
                        r_state  <= (w_b_full == '0) ? S_ERR : S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked first so it wins on the timeout edge.
                    if (div_done) begin
                        r_q     <= div_q;
                        r_r     <= div_r;
                        r_state <= S_SHOW;
                    end else if (r_cnt == CNT_LIM) begin
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_A_HI;
            endcase
        end
    end

    assign A_bin        = r_a;
    assign B_bin        = r_b;
    assign div_start    = (r_state == S_START);
    assign busy         = (r_state == S_START) || (r_state == S_WAIT);
    assign result_valid = (r_state == S_SHOW);
    assign err          = (r_state == S_ERR);

    always_comb begin
        disp_data  = {r_a, r_b};
        disp_blank = 4'b0000;
        case (r_state)
            S_A_HI: disp_blank = 4'b1111;
            S_A_LO: disp_blank = 4'b0111;
            S_B_HI: disp_blank = 4'b0011;
            S_B_LO: disp_blank = 4'b0001;
            S_SHOW: disp_data  = {r_q, r_r};
            S_ERR:  disp_data  = 16'hEEEE;
            default: begin
                disp_data  = {r_a, r_b};
                disp_blank = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_div_entry_ctrl.sv
module tb_div_entry_ctrl;

    localparam int W       = 8;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         clr;
    logic         div_done;
    logic [W-1:0] div_q, div_r;
    logic         div_start;
    logic [W-1:0] A_bin, B_bin;
    logic [15:0]  disp_data;
    logic [3:0]   disp_blank;
    logic         result_valid, err, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_entry_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .clr(clr), .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .div_start(div_start), .A_bin(A_bin), .B_bin(B_bin),
        .disp_data(disp_data), .disp_blank(disp_blank),
        .result_valid(result_valid), .err(err), .busy(busy)
    );

    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        cl;
        logic        dd;
        logic [7:0]  q;
        logic [7:0]  r;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [15:0] ed;
        logic [3:0]  ebl;
        logic [3:0]  ef;   // {div_start, result_valid, err, busy}
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [15:0] ed, input logic [3:0] ebl, input logic [3:0] ef);
        chk({nm, ".A"},     32'(A_bin), 32'(ea));
        chk({nm, ".B"},     32'(B_bin), 32'(eb));
        chk({nm, ".disp"},  32'(disp_data), 32'(ed));
        chk({nm, ".blank"}, 32'(disp_blank), 32'(ebl));
        chk({nm, ".flags"}, 32'({div_start, result_valid, err, busy}), 32'(ef));
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic tick(input logic kv, input logic [3:0] kc, input logic cl,
                        input logic dd, input logic [7:0] q, input logic [7:0] r);
        key_valid = kv; key_code = kc; clr = cl; div_done = dd; div_q = q; div_r = r;
        @(posedge clk);
        #1;
        key_valid = 1'b0; key_code = 4'h0; clr = 1'b0; div_done = 1'b0; div_q = '0; div_r = '0;
    endtask

    task automatic idle();
        tick(1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic key(input logic [3:0] k);
        tick(1'b1, k, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic enter(input logic [7:0] a, input logic [7:0] b);
        key(a[7:4]); key(a[3:0]); key(b[7:4]); key(b[3:0]);
    endtask

    initial begin
        logic [7:0] mq, mr;
        int early_err;

        tbl[0]  = '{1'b1, 4'h4, 1'b0, 1'b0, 8'h00, 8'h00, 8'h40, 8'h00, 16'h4000, 4'b0111, 4'b0000};
        tbl[1]  = '{1'b1, 4'h5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h45, 8'h00, 16'h4500, 4'b0011, 4'b0000};
        tbl[2]  = '{1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h45, 8'h00, 16'h4500, 4'b0001, 4'b0000};
        tbl[3]  = '{1'b1, 4'h7, 1'b0, 1'b0, 8'h00, 8'h00, 8'h45, 8'h07, 16'h4507, 4'b0000, 4'b1001};
        tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h45, 8'h07, 16'h4507, 4'b0000, 4'b0001};
        tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 8'h09, 8'h06, 8'h45, 8'h07, 16'h0906, 4'b0000, 4'b0100};
        tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h45, 8'h07, 16'h0906, 4'b0000, 4'b0100};
        tbl[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'h00, 16'h1000, 4'b0111, 4'b0000};
        tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h12, 8'h00, 16'h1200, 4'b0011, 4'b0000};
        tbl[9]  = '{1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h12, 8'h00, 16'h1200, 4'b0001, 4'b0000};
        tbl[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h12, 8'h00, 16'hEEEE, 4'b0000, 4'b0010};
        tbl[11] = '{1'b1, 4'h3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h30, 8'h00, 16'h3000, 4'b0111, 4'b0000};

        rst = 1'b0; key_valid = 1'b0; key_code = 4'h0; clr = 1'b0;
        div_done = 1'b0; div_q = '0; div_r = '0;
        #1;
        chk_all("reset", 8'h00, 8'h00, 16'h0000, 4'b1111, 4'b0000);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all("post_reset", 8'h00, 8'h00, 16'h0000, 4'b1111, 4'b0000);

        // Normal division and zero-divisor rejection
        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].kv, tbl[i].kc, tbl[i].cl, tbl[i].dd, tbl[i].q, tbl[i].r);
            chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ed, tbl[i].ebl, tbl[i].ef);
        end

        // Soft clear from A_LO
        tick(1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00);
        chk_all("clr_alo", 8'h00, 8'h00, 16'h0000, 4'b1111, 4'b0000);

        // Timeout: ERR exactly TIMEOUT edges after entering WAIT
        enter(8'h23, 8'h05);
        chk_all("to_start", 8'h23, 8'h05, 16'h2305, 4'b0000, 4'b1001);
        idle();
        early_err = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            idle();
            if (err !== 1'b0 || busy !== 1'b1) early_err++;
        end
        chk("to_still_wait", 32'(early_err), 32'd0);
        idle();
        chk_all("to_err", 8'h23, 8'h05, 16'hEEEE, 4'b0000, 4'b0010);

        // Done on the limit edge wins over timeout
        enter(8'h33, 8'h03);
        idle();
        for (int k = 1; k < TIMEOUT; k++) idle();
        mq = 8'h33 / 8'h03; mr = 8'h33 % 8'h03;
        tick(1'b0, 4'h0, 1'b0, 1'b1, mq, mr);
        chk_all("to_done_wins", 8'h33, 8'h03, 16'h1100, 4'b0000, 4'b0100);

        // Spurious done in START, keys in WAIT are dropped
        enter(8'h64, 8'h08);
        tick(1'b0, 4'h0, 1'b0, 1'b1, 8'hAA, 8'hBB);
        chk_all("spur_start", 8'h64, 8'h08, 16'h6408, 4'b0000, 4'b0001);
        key(4'h9); key(4'h1);
        chk_all("wait_keys", 8'h64, 8'h08, 16'h6408, 4'b0000, 4'b0001);
        mq = 8'h64 / 8'h08; mr = 8'h64 % 8'h08;
        tick(1'b0, 4'h0, 1'b0, 1'b1, mq, mr);
        chk_all("real_done", 8'h64, 8'h08, 16'h0C04, 4'b0000, 4'b0100);
        tick(1'b0, 4'h0, 1'b0, 1'b1, 8'h55, 8'h66);
        chk_all("done_in_show", 8'h64, 8'h08, 16'h0C04, 4'b0000, 4'b0100);

        // clr in B_HI with a simultaneous key
        key(4'h1); key(4'h2);
        chk_all("bhi", 8'h12, 8'h00, 16'h1200, 4'b0011, 4'b0000);
        tick(1'b1, 4'h5, 1'b1, 1'b0, 8'h00, 8'h00);
        chk_all("clr_bhi", 8'h00, 8'h00, 16'h0000, 4'b1111, 4'b0000);

        // clr in WAIT with a simultaneous done
        enter(8'h10, 8'h02);
        idle();
        tick(1'b0, 4'h0, 1'b1, 1'b1, 8'h08, 8'h00);
        chk_all("clr_wait", 8'h00, 8'h00, 16'h0000, 4'b1111, 4'b0000);
        idle();
        chk("clr_wait_rv", 32'(result_valid), 32'd0);

        // Asynchronous reset mid-WAIT
        enter(8'h50, 8'h03);
        idle(); idle(); idle();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 8'h00, 16'h0000, 4'b1111, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        enter(8'hFF, 8'h01);
        chk_all("ff01_start", 8'hFF, 8'h01, 16'hFF01, 4'b0000, 4'b1001);
        idle();
        mq = 8'hFF / 8'h01; mr = 8'hFF % 8'h01;
        tick(1'b0, 4'h0, 1'b0, 1'b1, mq, mr);
        chk_all("ff01_show", 8'hFF, 8'h01, 16'hFF00, 4'b0000, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
